// File: rtl/pipe_alu4_p.sv
// pipe_alu4_p: four-stage pipelined ALU with forwarding register bank and data memory
// Ports: clk, rst_n (async active-low reset)
//        in_valid, rs1, rs2, rd, func, addr : instruction issue
//        dbg_addr -> dbg_data               : registered memory read port
//        out_valid, zout, out_addr, out_err : stage-3 retiring instruction
module pipe_alu4_p #(
    parameter int DW   = 16,
    parameter int RA_W = 4,
    parameter int MA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] rd,
    input  logic [3:0]      func,
    input  logic [MA_W-1:0] addr,
    input  logic [MA_W-1:0] dbg_addr,
    output logic [DW-1:0]   dbg_data,
    output logic            out_valid,
    output logic [DW-1:0]   zout,
    output logic [MA_W-1:0] out_addr,
    output logic            out_err
);
    logic [DW-1:0]   regs [2**RA_W];
    logic [DW-1:0]   mem  [2**MA_W];
    logic            s1_valid;
    logic [DW-1:0]   s1_a;
    logic [DW-1:0]   s1_b;
    logic [RA_W-1:0] s1_rd;
    logic [3:0]      s1_func;
    logic [MA_W-1:0] s1_addr;
    logic            s2_valid;
    logic            s2_err;
    logic [DW-1:0]   s2_res;
    logic [RA_W-1:0] s2_rd;
    logic [MA_W-1:0] s2_addr;
    logic [DW-1:0]   alu;
    logic            s1_err;
    logic            s1_fwd;
    logic            s2_fwd;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;

    assign s1_err = s1_func[3] & s1_func[2];

    always_comb begin
        alu = '0;
        case (s1_func)
            4'd0:    alu = s1_a + s1_b;
            4'd1:    alu = s1_a - s1_b;
            4'd2:    alu = s1_a * s1_b;
            4'd3:    alu = s1_a;
            4'd4:    alu = s1_b;
            4'd5:    alu = s1_a & s1_b;
            4'd6:    alu = s1_a | s1_b;
            4'd7:    alu = s1_a ^ s1_b;
            4'd8:    alu = -s1_a;
            4'd9:    alu = -s1_b;
            4'd10:   alu = s1_a >> 1;
            4'd11:   alu = s1_b << 1;
            default: alu = '0;
        endcase
    end

    // Only legal, valid instructions may forward; the youngest producer wins.
    assign s1_fwd = s1_valid & ~s1_err;
    assign s2_fwd = s2_valid & ~s2_err;
    assign op_a = (s1_fwd && s1_rd == rs1) ? alu : (s2_fwd && s2_rd == rs1) ? s2_res : regs[rs1];
    assign op_b = (s1_fwd && s1_rd == rs2) ? alu : (s2_fwd && s2_rd == rs2) ? s2_res : regs[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_rd     <= '0;
            s1_func   <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_err    <= 1'b0;
            s2_res    <= '0;
            s2_rd     <= '0;
            s2_addr   <= '0;
            out_valid <= 1'b0;
            zout      <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            dbg_data  <= '0;
            for (int k = 0; k < 2**RA_W; k++) regs[k] <= DW'(k);
        end else begin
            s1_valid  <= in_valid;
            s1_a      <= op_a;
            s1_b      <= op_b;
            s1_rd     <= rd;
            s1_func   <= func;
            s1_addr   <= addr;
            s2_valid  <= s1_valid;
            s2_err    <= s1_valid & s1_err;
            s2_res    <= alu;
            s2_rd     <= s1_rd;
            s2_addr   <= s1_addr;
            out_valid <= s2_valid;
            zout      <= s2_res;
            out_addr  <= s2_addr;
            out_err   <= s2_err;
            dbg_data  <= mem[dbg_addr];
            if (s2_valid && !s2_err) regs[s2_rd] <= s2_res;
        end
    end

    // Memory is not reset; out_valid is cleared by reset so flushed work never lands here.
    always_ff @(posedge clk) begin
        if (out_valid && !out_err) mem[out_addr] <= zout;
    end
endmodule

// File: tb/tb_pipe_alu4_p.sv
// tb_pipe_alu4_p: randomized and directed checks of pipe_alu4_p against a sequential ISA model
module tb_pipe_alu4_p;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  rs1 = '0;
    logic [3:0]  rs2 = '0;
    logic [3:0]  rd = '0;
    logic [3:0]  func = '0;
    logic [7:0]  addr = '0;
    logic [7:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic        out_valid;
    logic [15:0] zout;
    logic [7:0]  out_addr;
    logic        out_err;

    pipe_alu4_p #(.DW(16), .RA_W(4), .MA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
        .func(func), .addr(addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .out_valid(out_valid), .zout(zout), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [15:0] z;
        logic [7:0]  a;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] reg_m [16];
    logic [15:0] mem_m [256];
    bit          mem_w [256];
    logic [15:0] mem_snap [256];
    exp_t        pipe [$];
    exp_t        ex;

    function automatic logic [16:0] ref_alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] x;
        x = 0;
        case (f)
            0: x = 32'(a) + 32'(b);
            1: x = 32'(a) + 32'h10000 - 32'(b);
            2: x = 32'(a) * 32'(b);
            3: x = 32'(a);
            4: x = 32'(b);
            5: x = 32'(a & b);
            6: x = 32'(a | b);
            7: x = 32'(a ^ b);
            8: x = 32'h10000 - 32'(a);
            9: x = 32'h10000 - 32'(b);
            10: x = 32'(a) / 2;
            11: x = 32'(b) * 2;
            default: return {1'b1, 16'h0};
        endcase
        return {1'b0, x[15:0]};
    endfunction

    task automatic issue(input bit v, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad);
        logic [16:0] res;
        exp_t e;
        in_valid = v; rs1 = s1; rs2 = s2; rd = d; func = f; addr = ad;
        e = '0;
        if (v) begin
            res = ref_alu(f, reg_m[s1], reg_m[s2]);
            e.v = 1'b1; e.e = res[16]; e.z = res[15:0]; e.a = ad;
            if (!res[16]) begin
                reg_m[d] = res[15:0];
                mem_m[ad] = res[15:0];
                mem_w[ad] = 1'b1;
            end
        end
        pipe.push_back(e);
        @(posedge clk);
        #1;
        ex = pipe.pop_front();
        in_valid = 1'b0;
    endtask

    task automatic bubble();
        issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) bubble();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) reg_m[k] = 16'(k);
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (zout !== 16'h0) begin errors++; $display("FAIL reset_zout: got %0h want 0", zout); end
        checks++; if (out_addr !== 8'h0) begin errors++; $display("FAIL reset_out_addr: got %0h want 0", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
        checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL reset_dbg_data: got %0h want 0", dbg_data); end
        do_reset();
    endtask

    task automatic test_regs();
        for (int i = 0; i < 18; i++) begin
            issue(i < 16, 4'(i), 4'd0, 4'(i), 4'd3, 8'(i));
            if (i >= 2) begin
                checks++;
                if ({out_valid, out_err, zout, out_addr} !== {1'b1, 1'b0, 16'(i - 2), 8'(i - 2)}) begin
                    errors++;
                    $display("FAIL reset_regbank[%0d]: got v=%0b e=%0b z=%0h a=%0h want v=1 e=0 z=%0h a=%0h",
                             i - 2, out_valid, out_err, zout, out_addr, i - 2, i - 2);
                end
            end
        end
    endtask

    task automatic test_add();
        issue(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd125);
        bubble();
        bubble();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        checks++; if (zout !== 16'd8) begin errors++; $display("FAIL add_zout: got %0h want 8", zout); end
        checks++; if (out_addr !== 8'd125) begin errors++; $display("FAIL add_addr: got %0d want 125", out_addr); end
        dbg_addr = 8'd125;
        bubble();
        bubble();
        checks++; if (dbg_data !== 16'd8) begin errors++; $display("FAIL add_mem: got %0h want 8", dbg_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(1'b1, 4'd3, 4'd5, 4'd10, 4'd0, 8'd1);
        issue(1'b1, 4'd10, 4'd5, 4'd14, 4'd1, 8'd2);
        bubble();
        checks++; if (zout !== 16'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got v=%0b z=%0h want v=1 z=8", out_valid, zout); end
        bubble();
        checks++; if (zout !== 16'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got v=%0b z=%0h want v=1 z=3", out_valid, zout); end
        issue(1'b1, 4'd14, 4'd0, 4'd14, 4'd3, 8'd3);
        bubble();
        bubble();
        checks++; if (zout !== 16'd3) begin errors++; $display("FAIL b2b_reg14: got %0h want 3", zout); end
    endtask

    task automatic test_dist2();
        do_reset();
        issue(1'b1, 4'd3, 4'd8, 4'd12, 4'd2, 8'd4);
        bubble();
        issue(1'b1, 4'd12, 4'd1, 4'd15, 4'd0, 8'd5);
        checks++; if (zout !== 16'd24 || out_valid !== 1'b1) begin errors++; $display("FAIL dist2_mul: got v=%0b z=%0h want v=1 z=18", out_valid, zout); end
        bubble();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dist2_bubble: got %0b want 0", out_valid); end
        bubble();
        checks++; if (zout !== 16'd25 || out_valid !== 1'b1) begin errors++; $display("FAIL dist2_add: got v=%0b z=%0h want v=1 z=19", out_valid, zout); end
    endtask

    task automatic test_wrap();
        do_reset();
        issue(1'b1, 4'd1, 4'd0, 4'd6, 4'd8, 8'd6);
        issue(1'b1, 4'd6, 4'd6, 4'd7, 4'd2, 8'd7);
        issue(1'b1, 4'd6, 4'd1, 4'd8, 4'd0, 8'd8);
        checks++; if (zout !== 16'hFFFF) begin errors++; $display("FAIL wrap_neg: got %0h want ffff", zout); end
        bubble();
        checks++; if (zout !== 16'h0001) begin errors++; $display("FAIL wrap_mul: got %0h want 1", zout); end
        bubble();
        checks++; if (zout !== 16'h0000 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_add: got v=%0b z=%0h want v=1 z=0", out_valid, zout); end
    endtask

    task automatic test_illegal();
        do_reset();
        issue(1'b1, 4'd9, 4'd0, 4'd9, 4'd3, 8'd200);
        issue(1'b1, 4'd0, 4'd0, 4'd2, 4'd13, 8'd200);
        issue(1'b1, 4'd2, 4'd0, 4'd3, 4'd3, 8'd201);
        checks++; if (zout !== 16'd9 || out_err !== 1'b0) begin errors++; $display("FAIL illegal_pre: got z=%0h e=%0b want z=9 e=0", zout, out_err); end
        bubble();
        checks++;
        if ({out_valid, out_err, zout} !== {1'b1, 1'b1, 16'h0}) begin
            errors++; $display("FAIL illegal_out: got v=%0b e=%0b z=%0h want v=1 e=1 z=0", out_valid, out_err, zout);
        end
        bubble();
        checks++; if (zout !== 16'd2 || out_err !== 1'b0) begin errors++; $display("FAIL illegal_r2: got z=%0h e=%0b want z=2 e=0", zout, out_err); end
        drain();
        dbg_addr = 8'd200;
        bubble();
        checks++; if (dbg_data !== 16'd9) begin errors++; $display("FAIL illegal_mem: got %0h want 9", dbg_data); end
    endtask

    task automatic test_rbw();
        do_reset();
        issue(1'b1, 4'd5, 4'd0, 4'd0, 4'd3, 8'd70);
        drain();
        dbg_addr = 8'd70;
        issue(1'b1, 4'd6, 4'd0, 4'd0, 4'd3, 8'd70);
        bubble();
        bubble();
        bubble();
        checks++; if (dbg_data !== 16'd5) begin errors++; $display("FAIL rbw_old: got %0h want 5", dbg_data); end
        bubble();
        checks++; if (dbg_data !== 16'd6) begin errors++; $display("FAIL rbw_new: got %0h want 6", dbg_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(16, 31)));
            checks++;
            if (out_valid !== ex.v) begin errors++; $display("FAIL random_valid[%0d]: got %0b want %0b", i, out_valid, ex.v); end
            if (ex.v) begin
                checks++;
                if ({out_err, out_addr, zout} !== {ex.e, ex.a, ex.z}) begin
                    errors++;
                    $display("FAIL random_out[%0d]: got e=%0b a=%0h z=%0h want e=%0b a=%0h z=%0h",
                             i, out_err, out_addr, zout, ex.e, ex.a, ex.z);
                end
            end
        end
        drain();
        for (int a = 16; a < 32; a++) begin
            if (mem_w[a]) begin
                dbg_addr = 8'(a);
                bubble();
                checks++;
                if (dbg_data !== mem_m[a]) begin errors++; $display("FAIL random_mem[%0d]: got %0h want %0h", a, dbg_data, mem_m[a]); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue(1'b1, 4'd7, 4'd0, 4'd13, 4'd3, 8'd50);
        issue(1'b1, 4'd8, 4'd0, 4'd13, 4'd3, 8'd51);
        issue(1'b1, 4'd9, 4'd0, 4'd13, 4'd3, 8'd52);
        drain();
        for (int a = 0; a < 256; a++) mem_snap[a] = mem_m[a];
        issue(1'b1, 4'd1, 4'd2, 4'd1, 4'd0, 8'd50);
        issue(1'b1, 4'd2, 4'd3, 4'd2, 4'd0, 8'd51);
        issue(1'b1, 4'd3, 4'd4, 4'd3, 4'd0, 8'd52);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_err, zout, out_addr} !== 26'h0) begin
            errors++; $display("FAIL flush_outputs: got v=%0b e=%0b z=%0h a=%0h want all 0", out_valid, out_err, zout, out_addr);
        end
        for (int a = 0; a < 256; a++) mem_m[a] = mem_snap[a];
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(i < 3, 4'(i + 1), 4'd0, 4'd14, 4'd3, 8'(60 + i));
            if (i >= 2) begin
                checks++;
                if (zout !== 16'(i - 1) || out_valid !== 1'b1) begin
                    errors++; $display("FAIL flush_reg[%0d]: got v=%0b z=%0h want v=1 z=%0h", i - 1, out_valid, zout, i - 1);
                end
            end
        end
        drain();
        for (int a = 50; a < 53; a++) begin
            dbg_addr = 8'(a);
            bubble();
            checks++;
            if (dbg_data !== 16'(a - 43)) begin errors++; $display("FAIL flush_mem[%0d]: got %0h want %0h", a, dbg_data, a - 43); end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem_m[a] = '0;
            mem_w[a] = 1'b0;
        end
        model_reset();
        test_reset();
        test_regs();
        test_add();
        test_back_to_back();
        test_dist2();
        test_wrap();
        test_illegal();
        test_rbw();
        test_random();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_alu4_p.md
PIPE_ALU4_P -- requirements
Module: pipe_alu4_p

Interface
REQ-001 Parameter DW, default 16, datapath and register width in bits.
REQ-002 Parameter RA_W, default 4, register address width; register bank holds 2**RA_W entries.
REQ-003 Parameter MA_W, default 8, memory address width; data memory holds 2**MA_W words of DW bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  instruction present on rs1/rs2/rd/func/addr this cycle.
REQ-007 rs1, rs2, rd  input  RA_W each  source and destination register addresses.
REQ-008 func  input  4  operation select.
REQ-009 addr  input  MA_W  memory address the result is stored to.
REQ-010 dbg_addr  input  MA_W  memory read address.
REQ-011 dbg_data  output  DW  registered memory read data.
REQ-012 out_valid  output  1  zout/out_addr/out_err hold a retiring instruction.
REQ-013 zout  output  DW  stage-3 result.
REQ-014 out_addr  output  MA_W  stage-3 memory address.
REQ-015 out_err  output  1  retiring instruction had an illegal func.

Function
REQ-016 Four stages, no backpressure; an instruction is accepted on every rising edge with in_valid=1.
REQ-017 S1: latch operands A/B, rd, func, addr, valid; S2: ALU result, rd, addr, valid, err; S3: regbank[rd] write, drive out_*; S4: mem[addr] write.
REQ-018 Timing: instruction accepted at edge N -> S2 at N+1 -> regbank write and out_valid=1 after edge N+2 -> mem write at edge N+3.
REQ-019 func: 0 A+B, 1 A-B, 2 A*B (low DW bits), 3 A, 4 B, 5 A&B, 6 A|B, 7 A^B, 8 -A, 9 -B, 10 A>>1 logical, 11 B<<1; all results modulo 2**DW, two's complement.
REQ-020 func 12-15 illegal: result 0, err=1, carried to S3/S4 with valid=1; no regbank write, no mem write; out_err=1 with out_valid=1.
REQ-021 Bubbles (in_valid=0) propagate valid=0; a stage with valid=0 performs no regbank or mem write, and out_valid=0.
REQ-022 Operand forwarding, priority highest first: (a) S1 instruction (valid, legal, rd match) -> current ALU output; (b) S2 instruction (valid, legal, rd match) -> S2 result; (c) regbank.
REQ-023 Forwarding applies independently to rs1 and rs2; no stall cycles ever inserted; any dependency distance yields architecturally sequential results.
REQ-024 Register 0 is an ordinary register (writable, forwardable).
REQ-025 dbg_data <= mem[dbg_addr] every edge; same-edge S4 write to the same address returns old data (read-before-write).
REQ-026 Memory contents are not reset; reads of unwritten locations are undefined.

Reset
REQ-027 rst_n=0 asynchronously clears all stage valid, err, data and address registers and dbg_data to 0; out_valid=0, zout=0, out_addr=0, out_err=0.
REQ-028 During reset regbank[k] = k (mod 2**DW) for every k.
REQ-029 Reset mid-operation flushes all in-flight instructions; none of them writes regbank or mem after reset asserts.
REQ-030 First instruction may be accepted at the first rising edge after rst_n deasserts.

Verification (DW=16, RA_W=4, MA_W=8, post-reset regbank[k]=k)
REQ-031 ADD rs1=3 rs2=5 rd=10 addr=125 at edge N -> after N+2 out_valid=1 zout=8 out_addr=125; regbank[10]=8; dbg read of 125 after N+3 gives 8.
REQ-032 Back-to-back: ADD r10=r3+r5, next edge SUB rd=14 rs1=10 rs2=5 -> zout 8 then 3; regbank[14]=3 (S1 forward).
REQ-033 Distance 2: MUL rd=12 rs1=3 rs2=8, bubble, ADD rd=15 rs1=12 rs2=1 -> zout 24, bubble (out_valid=0), 25 (S2 forward).
REQ-034 Wrap: func 8 rs1=1 rd=6, next func 2 rs1=6 rs2=6 rd=7 -> zout 0xFFFF then 0x0001; func 0 rs1=6 rs2=1 -> 0x0000.
REQ-035 Illegal func 13 rd=2 addr=200 -> out_valid=1 out_err=1 zout=0; regbank[2] stays 2; mem[200] unchanged; following instruction reading r2 gets 2.
REQ-036 Three instructions in flight, rst_n pulsed low mid-cycle -> outputs 0 immediately, regbank restored to k, no mem write to any of their addresses.
